booth_mul_arbiter: RTL and testbench

//  Shares one booth_radix4 sequential multiplier between N_REQ requesters.

---
 rtl/booth_mul_arbiter.sv | 178 +++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin arbiter sharing one sequential multiplier between requesters
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (shared with the multiplier)
//   req               per-requester request level, held until ack
//   req_m, req_q      packed operands, requester i at [i*W +: W]
//   ack               one-hot pulse: request accepted, operands latched
//   done              one-hot pulse: result valid for the owning requester
//   result            2*W product, held until the next completion
//   tmo               pulses with done when the multiplier never became ready
//   busy              high whenever the controller is not idle
//   mul_start         start pulse to the multiplier
//   mul_m, mul_q      latched operands to the multiplier
//   mul_ready, mul_p  multiplier ready flag and product
module booth_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*W-1:0]   req_m,
    input  logic [N_REQ*W-1:0]   req_q,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     done,
    output logic [2*W-1:0]       result,
    output logic                 tmo,
    output logic                 busy,
    output logic                 mul_start,
    output logic [W-1:0]         mul_m,
    output logic [W-1:0]         mul_q,
    input  logic                 mul_ready,
    input  logic [2*W-1:0]       mul_p
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        WAIT_RDY = 2'd2,
        WAIT_CLR = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [IW-1:0]  rr, rr_n;
    logic [IW-1:0]  owner, owner_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [N_REQ-1:0] ack_n, done_n;
    logic [2*W-1:0] result_n;
    logic           tmo_n, busy_n, start_n;
    logic [W-1:0]   m_n, q_n;

    logic           found;
    logic [IW-1:0]  win;
    logic [IW:0]    sum;
    logic [IW-1:0]  idx;
    logic [W-1:0]   m_sel, q_sel;

    // Scan requesters starting at the round-robin pointer, wrapping around;
    // the first asserted request wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_REQ))
                sum = sum - (IW+1)'(N_REQ);
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        m_sel = '0;
        q_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IW'(i)) begin
                m_sel = req_m[i*W +: W];
                q_sel = req_q[i*W +: W];
            end
        end
    end

    // Every output is computed here as a next value and registered below,
    // so nothing on an input reaches an output combinationally.
    always_comb begin
        state_n  = state;
        rr_n     = rr;
        owner_n  = owner;
        cnt_n    = cnt;
        ack_n    = '0;
        done_n   = '0;
        tmo_n    = 1'b0;
        start_n  = 1'b0;
        result_n = result;
        m_n      = mul_m;
        q_n      = mul_q;
        case (state)
            IDLE: begin
                if (found) begin
                    m_n        = m_sel;
                    q_n        = q_sel;
                    owner_n    = win;
                    ack_n[win] = 1'b1;
                    start_n    = 1'b1;
                    state_n    = START;
                end
            end
            START: begin
                cnt_n   = '0;
                state_n = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (mul_ready) begin
                    result_n      = mul_p;
                    done_n[owner] = 1'b1;
                    state_n       = WAIT_CLR;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    result_n      = '0;
                    done_n[owner] = 1'b1;
                    tmo_n         = 1'b1;
                    state_n       = WAIT_CLR;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT_CLR: begin
                // Ready must fall before the next start so a stale ready
                // can never complete the following operation.
                if (!mul_ready) begin
                    state_n = IDLE;
                    rr_n    = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr        <= '0;
            owner     <= '0;
            cnt       <= '0;
            ack       <= '0;
            done      <= '0;
            result    <= '0;
            tmo       <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_m     <= '0;
            mul_q     <= '0;
        end else begin
            state     <= state_n;
            rr        <= rr_n;
            owner     <= owner_n;
            cnt       <= cnt_n;
            ack       <= ack_n;
            done      <= done_n;
            result    <= result_n;
            tmo       <= tmo_n;
            busy      <= busy_n;
            mul_start <= start_n;
            mul_m     <= m_n;
            mul_q     <= q_n;
        end
    end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - self-checking bench for booth_mul_arbiter with a behavioural multiplier
module tb_booth_mul_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TP = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_m = '0;
    logic [N*W-1:0]   req_q = '0;
    logic [N-1:0]     ack, done;
    logic [2*W-1:0]   result;
    logic             tmo, busy, mul_start;
    logic [W-1:0]     mul_m, mul_q;
    logic             mul_ready;
    logic [2*W-1:0]   mul_p;

    int total = 0;
    int bad   = 0;

    booth_mul_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TP)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_m(req_m), .req_q(req_q),
        .ack(ack), .done(done), .result(result), .tmo(tmo), .busy(busy),
        .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
        .mul_ready(mul_ready), .mul_p(mul_p)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier partner: ready rises stub_lat cycles after start,
    // stays high for stub_hold cycles; stub_never suppresses ready entirely.
    int  stub_lat   = 2;
    int  stub_hold  = 1;
    bit  stub_never = 1'b0;
    int  stub_cnt, hold_cnt;
    bit  stub_busy;
    logic signed [2*W-1:0] prod;
    assign prod = $signed(mul_m) * $signed(mul_q);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_ready <= 1'b0;
            mul_p     <= '0;
            stub_busy <= 1'b0;
            stub_cnt  <= 0;
            hold_cnt  <= 0;
        end else if (mul_start) begin
            stub_busy <= 1'b1;
            stub_cnt  <= stub_lat;
            mul_ready <= 1'b0;
        end else if (stub_busy) begin
            if (stub_cnt <= 1) begin
                stub_busy <= 1'b0;
                if (!stub_never) begin
                    mul_ready <= 1'b1;
                    mul_p     <= prod;
                    hold_cnt  <= stub_hold;
                end
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end else if (mul_ready) begin
            if (hold_cnt <= 1) mul_ready <= 1'b0;
            else hold_cnt <= hold_cnt - 1;
        end
    end

    int start_cnt = 0;
    always @(negedge clk) if (mul_start) start_cnt++;

    // Reference model: round-robin pointer plus operands per requester.
    int m_rr = 0;
    int op_m [N];
    int op_q [N];

    function automatic int exp_winner();
        for (int k = 0; k < N; k++) begin
            if (req[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [2*W-1:0] expected_product(input int a, input int b);
        int p;
        p = a * b;
        return p[2*W-1:0];
    endfunction

    task automatic post(input int i, input int m, input int q);
        op_m[i] = m;
        op_q[i] = q;
        req_m[i*W +: W] = m[W-1:0];
        req_q[i*W +: W] = q[W-1:0];
        req[i] = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        req   = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_rr  = 0;
    endtask

    // Wait for the model's winner to be acked, then follow its op to idle.
    task automatic serve_one(input bit fast, input bit alter);
        int w, waited;
        bit got;
        logic [2*W-1:0] e;
        w = exp_winner();
        e = expected_product(op_m[w], op_q[w]);
        got = 1'b0;
        waited = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            waited++;
            if (ack != '0) got = 1'b1;
        end
        total++;
        if (!got || ack !== onehot(w) || mul_start !== 1'b1) begin
            bad++;
            $display("FAIL grant: ack=%b start=%b required ack=%b start=1", ack, mul_start, onehot(w));
        end
        if (fast) begin
            total++;
            if (waited != 1) begin
                bad++;
                $display("FAIL ack_latency: %0d cycles required 1", waited);
            end
        end
        req = req & ~ack;
        if (alter) req_m[w*W +: W] = 8'd15;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (done != '0) got = 1'b1;
        end
        total++;
        if (!got || done !== onehot(w) || result !== e || tmo !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL done: done=%b result=%0d tmo=%b busy=%b required done=%b result=%0d tmo=0 busy=1",
                     done, $signed(result), tmo, busy, onehot(w), $signed(e));
        end
        @(negedge clk);
        total++;
        if (done !== '0 || tmo !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%b tmo=%b required 0", done, tmo);
        end
        got = (busy == 1'b0);
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (busy == 1'b0) got = 1'b1;
        end
        total++;
        if (!got || result !== e) begin
            bad++;
            $display("FAIL idle_hold: busy=%b result=%0d required busy=0 result=%0d", busy, $signed(result), $signed(e));
        end
        m_rr = (w + 1) % N;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        total++;
        if (ack !== '0 || done !== '0 || tmo !== 1'b0 || busy !== 1'b0 || mul_start !== 1'b0 ||
            result !== '0 || mul_m !== '0 || mul_q !== '0) begin
            bad++;
            $display("FAIL reset: ack=%b done=%b tmo=%b busy=%b start=%b result=%h m=%h q=%h required all 0",
                     ack, done, tmo, busy, mul_start, result, mul_m, mul_q);
        end
        rst_n = 1'b1;
        m_rr  = 0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || ack !== '0) begin
            bad++;
            $display("FAIL idle_no_req: busy=%b ack=%b required 0", busy, ack);
        end
    endtask

    task automatic test_single();
        int s0;
        stub_lat = 3; stub_hold = 1;
        s0 = start_cnt;
        post(0, 7, 3);
        serve_one(1'b1, 1'b0);
        total++;
        if (start_cnt - s0 != 1) begin
            bad++;
            $display("FAIL start_pulses: %0d required 1", start_cnt - s0);
        end
    endtask

    task automatic test_all_four();
        apply_reset();
        stub_lat = 2; stub_hold = 2;
        post(0, 7, 3); post(1, -5, 4); post(2, 10, -2); post(3, -7, -7);
        for (int i = 0; i < N; i++) serve_one(1'b0, 1'b0);
    endtask

    task automatic test_fairness();
        apply_reset();
        stub_lat = 1; stub_hold = 1;
        post(2, 3, 4);
        serve_one(1'b0, 1'b0);
        post(0, 11, 2); post(2, -9, 9); post(3, 6, -6);
        for (int i = 0; i < 3; i++) serve_one(1'b0, 1'b0);
    endtask

    task automatic test_operand_change();
        stub_lat = 4; stub_hold = 1;
        post(0, 9, 5);
        serve_one(1'b0, 1'b1);
    endtask

    task automatic test_reset_mid();
        bit got;
        stub_lat = 10; stub_hold = 1;
        post(1, 12, 12);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (ack !== '0 || done !== '0 || tmo !== 1'b0 || busy !== 1'b0 || mul_start !== 1'b0 ||
            result !== '0 || mul_m !== '0 || mul_q !== '0) begin
            bad++;
            $display("FAIL reset_mid: done=%b busy=%b result=%h m=%h q=%h required all 0",
                     done, busy, result, mul_m, mul_q);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (done !== '0) begin
                bad++;
                $display("FAIL reset_no_done: done=%b required 0", done);
            end
        end
        rst_n = 1'b1;
        m_rr  = 0;
        stub_lat = 2;
        post(3, -100, 3);
        serve_one(1'b1, 1'b0);
    endtask

    task automatic test_timeout();
        int cyc;
        bit got;
        stub_never = 1'b1;
        post(1, 5, 5);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        req = '0;
        got = 1'b0;
        cyc = 0;
        for (int c = 0; c < 4 * TP && !got; c++) begin
            @(negedge clk);
            if (done != '0) got = 1'b1;
            else cyc++;
        end
        total++;
        if (!got || done !== onehot(1) || tmo !== 1'b1 || result !== '0 || cyc != TP) begin
            bad++;
            $display("FAIL timeout: done=%b tmo=%b result=%h wait=%0d required done=%b tmo=1 result=0 wait=%0d",
                     done, tmo, result, cyc, onehot(1), TP);
        end
        @(negedge clk);
        total++;
        if (done !== '0 || tmo !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_idle: done=%b tmo=%b busy=%b required 0", done, tmo, busy);
        end
        m_rr = 2;
        stub_never = 1'b0;
    endtask

    task automatic test_random();
        int mask;
        for (int it = 0; it < 24; it++) begin
            mask = (req == '0) ? $urandom_range(1, (1 << N) - 1) : $urandom_range(0, (1 << N) - 1);
            for (int i = 0; i < N; i++) begin
                if (mask[i] && !req[i])
                    post(i, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
            end
            stub_lat  = $urandom_range(1, 6);
            stub_hold = $urandom_range(1, 3);
            serve_one(1'b0, 1'b0);
        end
        while (req != '0) serve_one(1'b0, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_operand_change();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
